// File: rtl/wsc_pkg.sv
// Shared state encoding, default scan geometry and address type for the
// window scan controller and its address generator.
package wsc_pkg;

    localparam int DEF_IMG_W  = 16;
    localparam int DEF_IMG_H  = 16;
    localparam int DEF_WIN    = 4;
    localparam int DEF_STRIDE = 1;
    localparam int DEF_ADDR_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        NEXT,
        DONE
    } wsc_state_t;

    typedef logic [DEF_ADDR_W-1:0] wsc_addr_t;

endpackage

// File: rtl/window_addr_gen.sv
// Row-major address stepper for one WIN x WIN window: loads a base address,
// then steps +1 along a row and jumps to the next image row at row end.
module window_addr_gen
    import wsc_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int WIN    = DEF_WIN,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_value,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              first,
    output logic              last
);

    localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CW-1:0]     LAST_IDX = CW'(WIN - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - WIN + 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;

    always_comb begin
        addr_d = addr_q;
        row_d  = row_q;
        col_d  = col_q;
        if (ld) begin
            addr_d = ld_value;
            row_d  = '0;
            col_d  = '0;
        end else if (en) begin
            if (col_q == LAST_IDX) begin
                col_d  = '0;
                row_d  = (row_q == LAST_IDX) ? '0 : row_q + CW'(1);
                addr_d = addr_q + ROW_STEP;
            end else begin
                col_d  = col_q + CW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else begin
            addr_q <= addr_d;
            row_q  <= row_d;
            col_q  <= col_d;
        end
    end

    assign addr  = addr_q;
    assign first = (row_q == '0) && (col_q == '0);
    assign last  = (row_q == LAST_IDX) && (col_q == LAST_IDX);

endmodule

// File: rtl/window_scan_ctrl.sv
// Sliding-window scan controller: walks every WIN x WIN window of an image and
// emits its pixel read addresses. Optional WSC_BACKPRESSURE_EN adds out_ready.
module window_scan_ctrl
    import wsc_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int WIN    = DEF_WIN,
    parameter int STRIDE = DEF_STRIDE,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
`ifdef WSC_BACKPRESSURE_EN
    input  logic              out_ready,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              win_first,
    output logic              win_last,
    output logic [ADDR_W-1:0] win_x,
    output logic [ADDR_W-1:0] win_y,
    output logic              busy,
    output logic              done
);

    localparam logic [31:0] IMG_W_U  = 32'(IMG_W);
    localparam logic [31:0] IMG_H_U  = 32'(IMG_H);
    localparam logic [31:0] WIN_U    = 32'(WIN);
    localparam logic [31:0] STRIDE_U = 32'(STRIDE);

    wsc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] win_x_q, win_x_d;
    logic [ADDR_W-1:0] win_y_q, win_y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       next_x, next_y;
    logic              ready;
    logic              gen_ld, gen_en;
    logic              gen_first, gen_last;
    logic [ADDR_W-1:0] gen_addr;

`ifdef WSC_BACKPRESSURE_EN
    assign ready = out_ready;
`else
    assign ready = 1'b1;
`endif

    window_addr_gen #(
        .IMG_W  (IMG_W),
        .WIN    (WIN),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .ld       (gen_ld),
        .ld_value (base_q),
        .en       (gen_en),
        .addr     (gen_addr),
        .first    (gen_first),
        .last     (gen_last)
    );

    always_comb begin
        state_d = state_q;
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        base_d  = base_q;
        gen_ld  = 1'b0;
        gen_en  = 1'b0;
        next_x  = 32'(win_x_q) + STRIDE_U;
        next_y  = 32'(win_y_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    win_x_d = '0;
                    win_y_d = '0;
                    base_d  = '0;
                end
            end
            LOAD: begin
                gen_ld  = 1'b1;
                state_d = SCAN;
            end
            SCAN: begin
                if (ready) begin
                    gen_en = 1'b1;
                    if (gen_last) state_d = NEXT;
                end
            end
            NEXT: begin
                // Wrap to the next window row once another step in x would overrun the image.
                if (32'(win_x_q) + STRIDE_U + WIN_U > IMG_W_U) begin
                    next_x = '0;
                    next_y = 32'(win_y_q) + STRIDE_U;
                end
                win_x_d = ADDR_W'(next_x);
                win_y_d = ADDR_W'(next_y);
                base_d  = ADDR_W'(next_y * IMG_W_U + next_x);
                state_d = (next_y + WIN_U > IMG_H_U) ? DONE : LOAD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && busy) begin
            state_d = IDLE;
            gen_ld  = 1'b0;
            gen_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_x_q <= '0;
            win_y_q <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
            base_q  <= base_d;
        end
    end

    assign mem_rd    = (state_q == SCAN);
    assign mem_addr  = gen_addr;
    assign win_first = mem_rd & gen_first;
    assign win_last  = mem_rd & gen_last;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;
    assign busy      = (state_q == LOAD) || (state_q == SCAN) || (state_q == NEXT);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Scoreboard bench for window_scan_ctrl: stimulus queues expected addresses and
// done cycles, a negedge monitor pops and compares whatever the DUT presents.
module tb_window_scan_ctrl;

    localparam int IMG_W  = 16;
    localparam int IMG_H  = 16;
    localparam int WIN    = 4;
    localparam int STRIDE = 1;
    localparam int ADDR_W = 9;
    localparam int SCAN_CYCLES = 3043;

`ifdef WSC_BACKPRESSURE_EN
    localparam int BP_STALL = 3;
`else
    localparam int BP_STALL = 0;
`endif

    typedef struct {
        int addr;
        bit first;
        bit last;
        int wx;
        int wy;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              out_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              win_first;
    logic              win_last;
    logic [ADDR_W-1:0] win_x;
    logic [ADDR_W-1:0] win_y;
    logic              busy;
    logic              done;

    exp_t exp_q[$];
    int   done_q[$];
    exp_t head;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   c0;
    int   first_win[16] = '{0, 1, 2, 3, 16, 17, 18, 19, 32, 33, 34, 35, 48, 49, 50, 51};

    window_scan_ctrl #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .WIN    (WIN),
        .STRIDE (STRIDE),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
`ifdef WSC_BACKPRESSURE_EN
        .out_ready (out_ready),
`endif
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .win_first (win_first),
        .win_last  (win_last),
        .win_x     (win_x),
        .win_y     (win_y),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_txn(input int a, input int wx, input int wy, input bit f, input bit l);
        exp_t e;
        e.addr  = a % (1 << ADDR_W);
        e.first = f;
        e.last  = l;
        e.wx    = wx;
        e.wy    = wy;
        exp_q.push_back(e);
    endtask

    task automatic push_window(input int wx, input int wy, input int n);
        int k = 0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) begin
                if (k < n)
                    push_txn(wy * IMG_W + wx + r * IMG_W + c, wx, wy,
                             (r == 0) && (c == 0), (r == WIN - 1) && (c == WIN - 1));
                k++;
            end
    endtask

    task automatic push_scan(input bit hand_first);
        for (int wy = 0; wy + WIN <= IMG_H; wy += STRIDE)
            for (int wx = 0; wx + WIN <= IMG_W; wx += STRIDE) begin
                if (hand_first && wx == 0 && wy == 0) begin
                    for (int i = 0; i < 16; i++)
                        push_txn(first_win[i], 0, 0, i == 0, i == 15);
                end else begin
                    push_window(wx, wy, WIN * WIN);
                end
            end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"}, int'(mem_addr), 0);
        check({tag, "_mem_rd"}, int'(mem_rd), 0);
        check({tag, "_win_first"}, int'(win_first), 0);
        check({tag, "_win_last"}, int'(win_last), 0);
        check({tag, "_win_x"}, int'(win_x), 0);
        check({tag, "_win_y"}, int'(win_y), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    // Monitor: every presented address is compared against the queue head; it
    // is consumed only when accepted, so a stall checks that the output holds.
    always @(negedge clk) begin
        if (mem_rd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: got addr %0d, expected no read", mem_addr);
            end else begin
                head = exp_q[0];
                check("mem_addr", int'(mem_addr), head.addr);
                check("win_first", int'(win_first), int'(head.first));
                check("win_last", int'(win_last), int'(head.last));
                check("win_x", int'(win_x), head.wx);
                check("win_y", int'(win_y), head.wy);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (head.last)
                        $display("window x=%0d y=%0d last_addr=%0d cycle=%0d", head.wx, head.wy, head.addr, cyc);
                end
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
            end else begin
                check("done_cycle", cyc, done_q.pop_front());
                $display("done pulse cycle=%0d", cyc);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);

        // Full scan with a hand-written first window and optional stall at 17.
        #1;
        push_scan(1'b1);
        c0 = cyc;
        done_q.push_back(c0 + SCAN_CYCLES + BP_STALL);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!mem_rd && n < 10);
            check("first_rd_cycle", cyc, c0 + 2);
        end
`ifdef WSC_BACKPRESSURE_EN
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
`endif
        wait_done(4000);
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("scan_drained", exp_q.size(), 0);

        // Abort during the third address of window 5 (origin x=4).
        @(posedge clk);
        #1;
        for (int wx = 0; wx < 4; wx++) push_window(wx, 0, WIN * WIN);
        push_window(4, 0, 3);
        c0 = cyc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (75) @(posedge clk);
        #1 abort = 1'b1;
        check("abort_cycle", cyc, c0 + 76);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_mem_rd", int'(mem_rd), 0);
        check("abort_busy", int'(busy), 0);
        repeat (30) @(negedge clk);
        check("abort_drained", exp_q.size(), 0);

        // Restart from base 0, then reset mid-window-2 with start held high.
        @(posedge clk);
        #1;
        push_window(0, 0, WIN * WIN);
        push_window(1, 0, 2);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midscan_rst");
        check("rst_drained", exp_q.size(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        push_scan(1'b0);
        c0 = cyc;
        done_q.push_back(c0 + SCAN_CYCLES);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(4000);
        @(negedge clk);
        check("busy_after_done2", int'(busy), 0);
        check("rescan_drained", exp_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_scan_ctrl.md
WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 Parameters SHALL be:
- IMG_W, default 16, pixels per image row.
- IMG_H, default 16, image rows.
- WIN, default 4, window edge.
- STRIDE, default 1, window step in x and y.
- ADDR_W, default 9, address width.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high, on clk.
- start  in  1  begin scan pulse.
- abort  in  1  cancel scan.
- out_ready  in  1  downstream accepts address (WSC_BACKPRESSURE_EN only).
- mem_addr  out  ADDR_W  pixel read address.
- mem_rd  out  1  mem_addr valid.
- win_first  out  1  first address of a window.
- win_last  out  1  last address of a window.
- win_x  out  ADDR_W  window column origin.
- win_y  out  ADDR_W  window row origin.
- busy  out  1  scan in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, SCAN, NEXT, DONE.
REQ-004 IDLE SHALL leave on start=1 to LOAD, clearing win_x, win_y and base to 0; start in any other state SHALL be ignored.
REQ-005 LOAD SHALL last 1 cycle, loading base into the address generator, and go to SCAN.
REQ-006 SCAN SHALL emit WIN*WIN addresses row-major, base + r*IMG_W + c, one per advance, with mem_rd=1.
REQ-007 An advance SHALL occur on every SCAN cycle, or only when out_ready=1 if WSC_BACKPRESSURE_EN is defined.
REQ-008 win_first SHALL assert with (r,c)=(0,0) and win_last with (WIN-1,WIN-1), each gated by mem_rd.
REQ-009 The advance of the win_last address SHALL go to NEXT; mem_rd SHALL be 0 outside SCAN.
REQ-010 NEXT SHALL update the window origin:
- if win_x+STRIDE+WIN <= IMG_W, then win_x += STRIDE;
- otherwise win_x=0 and win_y += STRIDE, with base = win_y*IMG_W + win_x recomputed.
REQ-011 NEXT SHALL go to LOAD, or to DONE if the new win_y+WIN > IMG_H.
REQ-012 DONE SHALL assert done=1 for exactly 1 cycle and go to IDLE.
REQ-013 busy SHALL be 1 in LOAD, SCAN and NEXT, and 0 in IDLE and DONE.
REQ-014 abort=1 in any busy state SHALL force IDLE next cycle with no done pulse; abort SHALL take priority over advance.
REQ-015 With start sampled in cycle c0, the first mem_rd SHALL be in c0+2.
REQ-016 Window count SHALL be ((IMG_W-WIN)/STRIDE+1)*((IMG_H-WIN)/STRIDE+1), integer division.
REQ-017 With IMG_W==WIN, each window SHALL wrap to the next row.
REQ-018 Addresses SHALL be computed modulo 2^ADDR_W; IMG_W*IMG_H <= 2^ADDR_W is a legal-configuration requirement.

Reset
REQ-019 rst SHALL override all inputs, including mid-scan.
REQ-020 rst SHALL force IDLE, mem_addr=0, mem_rd=0, win_first=0, win_last=0, win_x=0, win_y=0, busy=0, done=0, and clear the generator counters.

Configuration
REQ-021 With WSC_BACKPRESSURE_EN defined, port out_ready SHALL exist, and mem_addr, win_first and win_last SHALL hold stable while mem_rd=1 and out_ready=0.
REQ-022 Without WSC_BACKPRESSURE_EN, out_ready SHALL be absent and treated as constant 1.

Structure
REQ-023 Package wsc_pkg SHALL hold the state enum type, default parameter constants and the ADDR_W-based address typedef.
REQ-024 Sub-module window_addr_gen SHALL implement the in-window address stepping:
- inputs ld, ld_value, en;
- outputs addr, first, last;
- +1 within a row, +(IMG_W-WIN+1) at row end.

Verification
REQ-025 With defaults, a start pulse SHALL produce first window addresses 0,1,2,3,16,17,18,19,32..35,48..51, with win_first on 0 and win_last on 51.
REQ-026 Window 2 SHALL have base 1, window 14 SHALL have base 16 (win_x=0, win_y=1), and the last window SHALL have base 204 with last address 255.
REQ-027 With defaults, done SHALL assert in cycle c0+3043 (169 windows x 18 cycles + 1), and busy SHALL be 0 the next cycle.
REQ-028 abort asserted in SCAN of window 5 SHALL give IDLE next cycle, mem_rd=0 and no done; a following start SHALL restart at base 0.
REQ-029 With WSC_BACKPRESSURE_EN and out_ready low for 3 cycles at address 17, mem_addr SHALL hold 17 for 3 cycles and then advance to 18.
REQ-030 rst asserted mid-scan with start held high SHALL give all outputs zero next cycle; after rst falls, a start SHALL restart at base 0.
